// File: rtl/dvp_pkg.sv
// Shared DVP definitions: FSM state type, byte order and default frame timing.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4,
    VFP    = 3'd5
  } dvp_state_e;

  // RGB565 pixels go out on the byte bus high byte first
  localparam logic DVP_BYTE_HI_FIRST = 1'b1;

  // Default timing, also used by the receiver-side bench
  localparam int DVP_IMG_HDISP  = 640;
  localparam int DVP_IMG_VDISP  = 480;
  localparam int DVP_VSYNC_CYC  = 32;
  localparam int DVP_VBP_CYC    = 64;
  localparam int DVP_HBLANK_CYC = 32;
  localparam int DVP_VFP_CYC    = 64;

  function automatic int dvp_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int dvp_frame_cycles(input int hdisp, input int vdisp, input int vsync_cyc,
                                          input int vbp_cyc, input int hblank_cyc, input int vfp_cyc);
    return vsync_cyc + vbp_cyc + vdisp * (2 * hdisp + hblank_cyc) + vfp_cyc;
  endfunction

endpackage

// File: rtl/dvp_byte_serializer.sv
// Turns one 16-bit pixel, delivered the cycle after its request, into two
// consecutive registered bytes. Outputs 8'h00 whenever no byte is due.
module dvp_byte_serializer
  import dvp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_req,
  input  logic [15:0] pix_data,
  output logic [7:0]  byte_out
);

  logic        cap_q, cap_d;
  logic        phase_q, phase_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  byte_q, byte_d;

  // Capture the pixel one cycle after its request, emit first byte, then second
  always_comb begin
    cap_d   = pix_req;
    hold_d  = hold_q;
    phase_d = 1'b0;
    byte_d  = 8'h00;
    if (cap_q) begin
      hold_d  = pix_data;
      phase_d = 1'b1;
      byte_d  = DVP_BYTE_HI_FIRST ? pix_data[15:8] : pix_data[7:0];
    end else if (phase_q) begin
      byte_d  = DVP_BYTE_HI_FIRST ? hold_q[7:0] : hold_q[15:8];
    end
  end

  // Serializer state and byte register, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q   <= 1'b0;
      phase_q <= 1'b0;
      hold_q  <= 16'h0000;
      byte_q  <= 8'h00;
    end else begin
      cap_q   <= cap_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
    end
  end

  assign byte_out = byte_q;

endmodule

// File: rtl/dvp_frame_transmitter.sv
// DVP source: generates vsync/href frame timing and pulls RGB565 pixels from
// a source two cycles ahead of the byte bus. All outputs are registered and
// computed from the next state, so they line up with the state register.
module dvp_frame_transmitter
  import dvp_pkg::*;
#(
  parameter int IMG_HDISP  = DVP_IMG_HDISP,
  parameter int IMG_VDISP  = DVP_IMG_VDISP,
  parameter int VSYNC_CYC  = DVP_VSYNC_CYC,
  parameter int VBP_CYC    = DVP_VBP_CYC,
  parameter int HBLANK_CYC = DVP_HBLANK_CYC,
  parameter int VFP_CYC    = DVP_VFP_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pix_data,
  output logic        pix_req,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy,
  output logic        ov5640_vsync,
  output logic        ov5640_href,
  output logic [7:0]  ov5640_data
);

  // One cycle counter is shared by the blanking states; it is sized for the longest
  localparam int TW = $clog2(dvp_max4(VSYNC_CYC, VBP_CYC, HBLANK_CYC, VFP_CYC) + 1);
  localparam int XW = $clog2(IMG_HDISP + 1);
  localparam int YW = $clog2(IMG_VDISP + 1);

  dvp_state_e     state_q, state_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           ph_q, ph_d;
  logic           req_q, req_d;
  logic           fs_q, fs_d;
  logic           fd_q, fd_d;
  logic           busy_q, busy_d;
  logic           vs_q, vs_d;
  logic           href_q, href_d;

  // Next state and counters; y counts lines already sent in this frame
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    x_d     = x_q;
    y_d     = y_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = VSYNC;
          tcnt_d  = '0;
          y_d     = '0;
        end
      end
      VSYNC: begin
        if (int'(tcnt_q) == VSYNC_CYC - 1) begin
          state_d = VBP;
          tcnt_d  = '0;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      VBP: begin
        if (int'(tcnt_q) == VBP_CYC - 1) begin
          state_d = ACTIVE;
          x_d     = '0;
          ph_d    = 1'b0;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (int'(x_q) == IMG_HDISP - 1) begin
            state_d = HBLANK;
            tcnt_d  = '0;
            x_d     = '0;
            y_d     = y_q + 1'b1;
          end else begin
            x_d     = x_q + 1'b1;
          end
        end
      end
      HBLANK: begin
        if (int'(tcnt_q) == HBLANK_CYC - 1) begin
          tcnt_d = '0;
          if (int'(y_q) < IMG_VDISP) begin
            state_d = ACTIVE;
            x_d     = '0;
            ph_d    = 1'b0;
          end else begin
            state_d = VFP;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      VFP: begin
        if (int'(tcnt_q) == VFP_CYC - 1) begin
          tcnt_d  = '0;
          y_d     = '0;
          state_d = en ? VSYNC : IDLE;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from that cycle's state
  always_comb begin
    fs_d   = (state_d == VSYNC) && (tcnt_d == '0) && (state_q != VSYNC);
    fd_d   = (state_d == VFP) && (int'(tcnt_d) == VFP_CYC - 1);
    busy_d = (state_d != IDLE);
    vs_d   = (state_d == VSYNC);
    href_d = (state_d == ACTIVE);
    // A request leads its high byte on the bus by two cycles
    case (state_d)
      VBP:     req_d = (int'(tcnt_d) == VBP_CYC - 2);
      HBLANK:  req_d = (int'(tcnt_d) == HBLANK_CYC - 2) && (int'(y_d) < IMG_VDISP);
      ACTIVE:  req_d = !ph_d && (int'(x_d) + 1 < IMG_HDISP);
      default: req_d = 1'b0;
    endcase
  end

  // FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ph_q    <= 1'b0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      vs_q    <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ph_q    <= ph_d;
      req_q   <= req_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      vs_q    <= vs_d;
      href_q  <= href_d;
    end
  end

  dvp_byte_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_req  (req_q),
    .pix_data (pix_data),
    .byte_out (ov5640_data)
  );

  assign pix_req      = req_q;
  assign frame_start  = fs_q;
  assign frame_done   = fd_q;
  assign busy         = busy_q;
  assign ov5640_vsync = vs_q;
  assign ov5640_href  = href_q;

endmodule

// File: tb/tb_dvp_frame_transmitter.sv
// Bench for dvp_frame_transmitter on a small frame: a pixel source answers
// requests and queues the expected bytes; a monitor compares every cycle
// against a frame-position model built from the timing arithmetic.
module tb_dvp_frame_transmitter;
  import dvp_pkg::*;

  localparam int H    = 4;
  localparam int VD   = 2;
  localparam int VS   = 3;
  localparam int VBPC = 4;
  localparam int HB   = 2;
  localparam int VFPC = 3;
  localparam int LINE = 2 * H + HB;
  localparam int ACT  = VD * LINE;
  localparam int L    = VS + VBPC + ACT + VFPC;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] pix_data;
  logic        pix_req;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic        ov5640_vsync;
  logic        ov5640_href;
  logic [7:0]  ov5640_data;

  int checks;
  int errors;

  logic [7:0]  exp_q[$];
  logic [15:0] dir_q[$];

  bit m_in;
  int m_pos;
  bit en_prev;
  int done_seen;
  int done_exp;
  int req_seen;

  dvp_frame_transmitter #(
    .IMG_HDISP  (H),
    .IMG_VDISP  (VD),
    .VSYNC_CYC  (VS),
    .VBP_CYC    (VBPC),
    .HBLANK_CYC (HB),
    .VFP_CYC    (VFPC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pix_data     (pix_data),
    .pix_req      (pix_req),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .busy         (busy),
    .ov5640_vsync (ov5640_vsync),
    .ov5640_href  (ov5640_href),
    .ov5640_data  (ov5640_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel source: answers a request on the following cycle and queues its bytes
  initial begin
    logic [15:0] p;
    forever begin
      @(negedge clk);
      if (rst_n && pix_req) begin
        @(posedge clk);
        #1;
        if (dir_q.size() > 0) p = dir_q.pop_front();
        else p = 16'($urandom);
        pix_data = p;
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
  end

  // Monitor: advance the frame-position model one cycle and compare all outputs
  always @(negedge clk) begin
    int q;
    int r;
    bit e_vs, e_href, e_req, e_fs, e_fd;
    logic [7:0] eb;
    if (!rst_n) begin
      m_in    = 1'b0;
      m_pos   = 0;
      en_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (m_in && m_pos == L - 1) begin
        m_in  = en_prev;
        m_pos = 0;
      end else if (m_in) begin
        m_pos++;
      end else if (en_prev) begin
        m_in  = 1'b1;
        m_pos = 0;
      end
      q      = m_pos - VS - VBPC;
      r      = q + 2;
      e_vs   = m_in && (m_pos < VS);
      e_href = m_in && (q >= 0) && (q < ACT) && ((q % LINE) < 2 * H);
      e_req  = m_in && (r >= 0) && (r < ACT) && ((r % LINE) < 2 * H) && (((r % LINE) % 2) == 0);
      e_fs   = m_in && (m_pos == 0);
      e_fd   = m_in && (m_pos == L - 1);
      if (e_fd) done_exp++;
      if (frame_done) done_seen++;
      if (pix_req) req_seen++;
      check("busy", 32'(busy), 32'(m_in));
      check("vsync", 32'(ov5640_vsync), 32'(e_vs));
      check("href", 32'(ov5640_href), 32'(e_href));
      check("pix_req", 32'(pix_req), 32'(e_req));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      if (ov5640_href) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data: got %0h with href but no byte was expected at %0t", ov5640_data, $time);
        end else begin
          eb = exp_q.pop_front();
          check("data", 32'(ov5640_data), 32'(eb));
        end
      end else begin
        check("data_idle", 32'(ov5640_data), 32'h0);
      end
      en_prev = en;
    end
  end

  // Stimulus: single frame, back-to-back frames with en dropped, reset mid-line, random en
  initial begin
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    done_exp  = 0;
    req_seen  = 0;
    m_in      = 1'b0;
    m_pos     = 0;
    en_prev   = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b0;
    pix_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    dir_q.push_back(16'hA5C3);
    dir_q.push_back(16'h1234);
    dir_q.push_back(16'hBEEF);
    dir_q.push_back(16'h0F0F);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (L + 8) @(posedge clk);
    #1;
    check("single_frame_done", 32'(done_seen), 32'd1);
    check("single_frame_reqs", 32'(req_seen), 32'(H * VD));

    en = 1'b1;
    repeat (2 * L + VS + VBPC + 3) @(posedge clk);
    #1 en = 1'b0;
    repeat (L + 8) @(posedge clk);
    #1;
    check("b2b_frames_done", 32'(done_seen), 32'd4);
    check("b2b_reqs", 32'(req_seen), 32'(4 * H * VD));

    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (VS + VBPC + 3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (L + 8) @(posedge clk);
    #1;

    repeat (600) begin
      @(posedge clk);
      #1;
      en    = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
    end
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (L + 8) @(posedge clk);
    #1;
    check("frames_done_total", 32'(done_seen), 32'(done_exp));
    check("idle_at_end", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
